// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 16-word block, then emits W0..W(ROUNDS-1) from a 16-word sliding window.
// Optional macro SHA256_MSG_SCHED_ROUND_IDX_EN adds out_round, the index t of the word on out_data.
module sha256_msg_sched #(
   parameter int DATA_W = 32,
   parameter int ROUNDS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
   output logic [5:0]        out_round,
`endif
   output logic              busy,
   output logic              done
);

   // state  | meaning
   // IDLE   | waiting for start
   // LOAD   | shifting the 16 message words into the window
   // GEN    | presenting window[0], extending the window on each transfer
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_GEN  = 2'd2;

   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   function automatic logic [31:0] f_sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] f_sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   logic [1:0]        r_state;
   logic [3:0]        r_load_cnt;
   logic [5:0]        r_round;
   logic              r_done;
   logic [DATA_W-1:0] r_win [16];
   logic [DATA_W-1:0] w_next;

   assign w_next = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

   // Handshake outputs are pure state decodes, so no input reaches them combinationally.
   assign in_ready  = (r_state == S_LOAD);
   assign out_valid = (r_state == S_GEN);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign out_data  = out_valid ? r_win[0] : '0;
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
   assign out_round = out_valid ? r_round : 6'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_load_cnt <= 4'd0;
         r_round    <= 6'd0;
         r_done     <= 1'b0;
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LOAD;
                  r_load_cnt <= 4'd0;
                  r_round    <= 6'd0;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                  r_win[15]  <= in_data;
                  r_load_cnt <= r_load_cnt + 4'd1;
                  if (r_load_cnt == 4'd15) r_state <= S_GEN;
               end
            end
            S_GEN: begin
               if (out_ready) begin
                  for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                  r_win[15] <= w_next;
                  r_round   <= r_round + 6'd1;
                  if (r_round == LAST_ROUND) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: full 64-round instance plus a ROUNDS=16 instance.
module tb_sha256_msg_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid, busy, done;
   logic [31:0] out_data;
   logic        s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
   logic [31:0] s_in_data = '0;
   logic        s_in_ready, s_out_valid, s_busy, s_done;
   logic [31:0] s_out_data;
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
   logic [5:0]  out_round, s_out_round;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [31:0] blk   [16];
   logic [31:0] exp_w [64];
   logic [31:0] got_w [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sha256_msg_sched #(.DATA_W(32), .ROUNDS(64)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
      .out_round(out_round),
`endif
      .busy(busy), .done(done)
   );

   sha256_msg_sched #(.DATA_W(32), .ROUNDS(16)) dut16 (
      .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
      .out_round(s_out_round),
`endif
      .busy(s_busy), .done(s_done)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic compute_model();
      for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      compute_model();
   endtask

   task automatic set_seq();
      for (int i = 0; i < 16; i++) blk[i] = (32'(i + 1) * 32'h9E3779B9) ^ 32'h0F0F1234;
      compute_model();
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         n_err++; $display("FAIL start_to_in_ready: in_ready=%b busy=%b, expected 1 1", in_ready, busy);
      end
   endtask

   task automatic load_words(input int stall_after, input bit poke_start);
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL load_ready word %0d: in_ready=%b out_valid=%b, expected 1 0", i, in_ready, out_valid);
         end
         in_valid = 1'b1; in_data = blk[i]; start = poke_start && (i == 3);
         tick();
         in_valid = 1'b0; start = 1'b0;
         if (i == stall_after) begin
            for (int k = 0; k < 3; k++) begin
               in_data = 32'hBAD0BAD0;
               tick();
               n_cmp++;
               if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                  n_err++; $display("FAIL load_stall cyc %0d: in_ready=%b out_valid=%b, expected 1 0", k, in_ready, out_valid);
               end
            end
         end
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_w[0]) begin
         n_err++; $display("FAIL first_w0: out_valid=%b out_data=%h, expected 1 %h", out_valid, out_data, exp_w[0]);
      end
   endtask

   task automatic drain(input int mode, input int stop_at, input bit poke, input bit pulse_chk);
      int idx, stall, budget, first_cyc;
      logic [15:0] lfsr;
      idx = 0; stall = 0; budget = 0; lfsr = 16'hACE1; first_cyc = cyc;
      while (idx < 64 && idx != stop_at && budget < 400) begin
         n_cmp++;
         if (out_valid !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL gen_flags t=%0d: valid=%b done=%b in_ready=%b busy=%b, expected 1 0 0 1", idx, out_valid, done, in_ready, busy);
            break;
         end
         n_cmp++;
         if (out_data !== exp_w[idx]) begin
            n_err++; $display("FAIL w_seq t=%0d: out_data=%h, expected %h", idx, out_data, exp_w[idx]);
         end
         got_w[idx] = out_data;
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
         n_cmp++;
         if (out_round !== 6'(idx)) begin
            n_err++; $display("FAIL out_round t=%0d: got %0d, expected %0d", idx, out_round, idx);
         end
`endif
         if (mode == 0) out_ready = 1'b1;
         else begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (idx == 16 && stall < 10) begin out_ready = 1'b0; stall++; end
            else out_ready = lfsr[0];
         end
         start    = poke && (idx == 5);
         in_valid = poke && (idx >= 5) && (idx < 8);
         in_data  = 32'hDEADBEEF;
         if (out_ready) idx++;
         tick(); budget++;
      end
      out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
      if (stop_at < 0) begin
         n_cmp++;
         if (idx != 64) begin
            n_err++; $display("FAIL transfer_count: got %0d transfers, expected 64", idx);
         end
         n_cmp++;
         if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            n_err++; $display("FAIL done_pulse: done=%b valid=%b busy=%b data=%h, expected 1 0 0 0", done, out_valid, busy, out_data);
         end
         if (mode == 0) begin
            n_cmp++;
            if (cyc - first_cyc != 64) begin
               n_err++; $display("FAIL gen_latency: %0d cycles first valid to done, expected 64", cyc - first_cyc);
            end
         end
         if (pulse_chk) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
               n_err++; $display("FAIL done_one_cycle: done=%b busy=%b valid=%b, expected 0 0 0", done, busy, out_valid);
            end
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({in_ready, out_valid, busy, done, s_in_ready, s_out_valid, s_busy, s_done} !== 8'h00 ||
          out_data !== 32'h0 || s_out_data !== 32'h0) begin
         n_err++; $display("FAIL reset_outputs: flags=%b data=%h, expected all 0", {in_ready, out_valid, busy, done}, out_data);
      end
      tick(); tick();
      rst = 1'b0;
      in_valid = 1'b1; in_data = 32'h12345678;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_idle: busy=%b in_ready=%b, expected 0 0", busy, in_ready);
      end
   endtask

   task automatic test_abc();
      set_abc();
      do_start();
      load_words(-1, 1'b0);
      drain(0, -1, 1'b0, 1'b1);
      n_cmp++;
      if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018) begin
         n_err++; $display("FAIL abc_echo: W0=%h W15=%h, expected 61626380 00000018", got_w[0], got_w[15]);
      end
      n_cmp++;
      if (got_w[16] !== 32'h61626380) begin
         n_err++; $display("FAIL abc_w16: got %h, expected 61626380", got_w[16]);
      end
      n_cmp++;
      if (got_w[17] !== 32'h000F0000) begin
         n_err++; $display("FAIL abc_w17: got %h, expected 000f0000", got_w[17]);
      end
      n_cmp++;
      if (got_w[18] !== 32'h7DA86405) begin
         n_err++; $display("FAIL abc_w18: got %h, expected 7da86405", got_w[18]);
      end
   endtask

   task automatic test_backpressure();
      set_abc();
      do_start();
      load_words(-1, 1'b0);
      drain(1, -1, 1'b0, 1'b1);
   endtask

   task automatic test_input_stall();
      set_seq();
      do_start();
      load_words(7, 1'b0);
      drain(0, -1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      set_abc();
      do_start();
      load_words(-1, 1'b0);
      drain(0, 20, 1'b0, 1'b0);
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, busy, done} !== 4'h0 || out_data !== 32'h0) begin
         n_err++; $display("FAIL reset_mid: flags=%b data=%h, expected 0000 0", {in_ready, out_valid, busy, done}, out_data);
      end
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
      n_cmp++;
      if (out_round !== 6'd0) begin
         n_err++; $display("FAIL reset_round: got %0d, expected 0", out_round);
      end
`endif
      tick();
      rst = 1'b0;
      tick();
      set_seq();
      do_start();
      load_words(-1, 1'b0);
      drain(0, -1, 1'b0, 1'b1);
   endtask

   task automatic test_protocol();
      int t0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 32'hCAFE0000 + 32'(k);
         tick();
         n_cmp++;
         if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_in_valid: in_ready=%b busy=%b, expected 0 0", in_ready, busy);
         end
      end
      in_valid = 1'b0;
      set_abc();
      do_start();
      load_words(-1, 1'b1);
      drain(0, -1, 1'b1, 1'b0);
      set_seq();
      t0 = cyc;
      do_start();
      load_words(-1, 1'b0);
      n_cmp++;
      if (cyc - t0 != 17) begin
         n_err++; $display("FAIL back_to_back_latency: %0d cycles, expected 17", cyc - t0);
      end
      drain(0, -1, 1'b0, 1'b1);
   endtask

   task automatic test_rounds16();
      set_abc();
      s_start = 1'b1; tick(); s_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_in_valid = 1'b1; s_in_data = blk[i]; tick();
      end
      s_in_valid = 1'b0; s_out_ready = 1'b1;
      for (int t = 0; t < 16; t++) begin
         n_cmp++;
         if (s_out_valid !== 1'b1 || s_out_data !== exp_w[t] || s_done !== 1'b0) begin
            n_err++; $display("FAIL r16_seq t=%0d: valid=%b data=%h done=%b, expected 1 %h 0", t, s_out_valid, s_out_data, s_done, exp_w[t]);
         end
`ifdef SHA256_MSG_SCHED_ROUND_IDX_EN
         n_cmp++;
         if (s_out_round !== 6'(t)) begin
            n_err++; $display("FAIL r16_round t=%0d: got %0d, expected %0d", t, s_out_round, t);
         end
`endif
         tick();
      end
      n_cmp++;
      if (s_done !== 1'b1 || s_out_valid !== 1'b0 || s_busy !== 1'b0) begin
         n_err++; $display("FAIL r16_done: done=%b valid=%b busy=%b, expected 1 0 0", s_done, s_out_valid, s_busy);
      end
      tick();
      s_out_ready = 1'b0;
      n_cmp++;
      if (s_done !== 1'b0 || s_out_valid !== 1'b0) begin
         n_err++; $display("FAIL r16_after: done=%b valid=%b, expected 0 0", s_done, s_out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_input_stall();
      test_reset_mid();
      test_protocol();
      test_rounds16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
